systolic_dma_ctrl: RTL and testbench

Command-driven data mover between the dual-port RAM (one port) and the systolic array.
- LOAD_TOP / LOAD_LEFT: stream MATRIX_SIZE bytes from RAM into the top or left operand buffer, with an optional buffer swap afterwards.
- STORE_ACC: drain all MATRIX_SIZE*MATRIX_SIZE accumulators into RAM as little-endian byte groups.
- Sits between the instruction-sequencing FSM (command issuer) and the systolic_module / dp_ram instances.

---
 rtl/systolic_dma_ctrl_pkg.sv | 22 ++
 rtl/systolic_dma_ctrl_if.sv | 25 ++
 rtl/systolic_dma_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_systolic_dma_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_dma_ctrl_pkg.sv
// Shared types for the systolic controller slice: DMA command opcodes and DMA FSM states.
// The instruction-sequencing FSM imports this package as well.
package systolic_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_TOP  = 2'd0,
    OP_LOAD_LEFT = 2'd1,
    OP_STORE_ACC = 2'd2,
    OP_ILLEGAL   = 2'd3
  } dma_op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_RD   = 3'd1,
    LD_LAST = 3'd2,
    SWAP    = 3'd3,
    ST_SEL  = 3'd4,
    ST_WR   = 3'd5,
    FIN     = 3'd6
  } dma_state_t;

endpackage

// File: rtl/systolic_dma_ctrl_if.sv
// Command handshake between the instruction sequencer (master) and the DMA controller (slave).
interface systolic_dma_ctrl_if #(
  parameter int DP_ADDR_WIDTH = 10
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [DP_ADDR_WIDTH-1:0] cmd_base;
  logic                     cmd_swap;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_swap,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_swap,
    output cmd_ready, busy, done, err
  );

endinterface

// File: rtl/systolic_dma_ctrl.sv
// Command-driven mover between one dual-port RAM port and the systolic array operand buffers
// and accumulators. Every output is a flop; values computed in a state appear the next cycle.
module systolic_dma_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_WIDTH      = 32,
  parameter int DP_ADDR_WIDTH  = 10,
  parameter int ADDR_WIDTH     = $clog2(MATRIX_SIZE),
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE),
  parameter int BYTES_PER_ACC  = ACC_WIDTH / DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  systolic_dma_ctrl_if.slave        cmd,
  output logic                      ram_we,
  output logic [DP_ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_din,
  input  logic [DATA_WIDTH-1:0]     ram_dout,
  output logic                      load_en_top,
  output logic                      swap_buffers_top,
  output logic [ADDR_WIDTH-1:0]     addr_top,
  output logic [DATA_WIDTH-1:0]     data_in_top,
  output logic                      load_en_left,
  output logic                      swap_buffers_left,
  output logic [ADDR_WIDTH-1:0]     addr_left,
  output logic [DATA_WIDTH-1:0]     data_in_left,
  output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
  input  logic [ACC_WIDTH-1:0]      acc_out
);

  localparam int CNT_W  = ACC_ADDR_WIDTH;
  localparam int BYTE_W = (BYTES_PER_ACC > 1) ? $clog2(BYTES_PER_ACC) : 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LD_LASTI = CNT_W'(MATRIX_SIZE - 1);
  localparam logic [CNT_W-1:0]  ST_LASTK = CNT_W'(MATRIX_SIZE * MATRIX_SIZE - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_ACC - 1);

  dma_state_t               state_q, state_d;
  dma_op_t                  op_q, op_d;
  logic [DP_ADDR_WIDTH-1:0] base_q, base_d;
  logic                     swap_q, swap_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BYTE_W-1:0]        byte_q, byte_d;
  logic                     phase_q, phase_d;
  logic [ACC_WIDTH-1:0]     shift_q, shift_d;

  logic                      cmd_ready_q, cmd_ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      ram_we_q, ram_we_d;
  logic [DP_ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]     ram_din_q, ram_din_d;
  logic                      load_en_top_q, load_en_top_d;
  logic                      swap_top_q, swap_top_d;
  logic [ADDR_WIDTH-1:0]     addr_top_q, addr_top_d;
  logic [DATA_WIDTH-1:0]     data_top_q, data_top_d;
  logic                      load_en_left_q, load_en_left_d;
  logic                      swap_left_q, swap_left_d;
  logic [ADDR_WIDTH-1:0]     addr_left_q, addr_left_d;
  logic [DATA_WIDTH-1:0]     data_left_q, data_left_d;
  logic [ACC_ADDR_WIDTH-1:0] addr_acc_q, addr_acc_d;

  logic                     ld_we;
  logic                     ld_swap;
  logic [ADDR_WIDTH-1:0]    ld_idx;
  logic                     sel_left;
  logic [DP_ADDR_WIDTH-1:0] st_off;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    base_d      = base_q;
    swap_d      = swap_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    phase_d     = phase_q;
    shift_d     = shift_q;
    cmd_ready_d = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = '0;
    addr_acc_d  = addr_acc_q;
    ld_we       = 1'b0;
    ld_swap     = 1'b0;
    ld_idx      = '0;
    sel_left    = (op_q == OP_LOAD_LEFT);
    st_off      = DP_ADDR_WIDTH'(cnt_q) * DP_ADDR_WIDTH'(BYTES_PER_ACC)
                + DP_ADDR_WIDTH'(byte_q);

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd.cmd_valid && cmd_ready_q) begin
          op_d   = dma_op_t'(cmd.cmd_op);
          base_d = cmd.cmd_base;
          swap_d = cmd.cmd_swap;
          cnt_d  = '0;
          unique case (dma_op_t'(cmd.cmd_op))
            OP_ILLEGAL: err_d = 1'b1;
            OP_STORE_ACC: begin
              state_d     = ST_SEL;
              phase_d     = 1'b0;
              byte_d      = '0;
              addr_acc_d  = '0;
              cmd_ready_d = 1'b0;
              busy_d      = 1'b1;
            end
            default: begin
              state_d     = LD_RD;
              ram_addr_d  = cmd.cmd_base;
              cmd_ready_d = 1'b0;
              busy_d      = 1'b1;
            end
          endcase
        end
      end
      // RAM read data trails its address by a cycle, so buffer index i-1 is written while reading i.
      LD_RD: begin
        if (cnt_q != '0) begin
          ld_we  = 1'b1;
          ld_idx = ADDR_WIDTH'(cnt_q - CNT_ONE);
        end
        if (cnt_q == LD_LASTI) begin
          state_d = LD_LAST;
        end else begin
          cnt_d      = cnt_q + CNT_ONE;
          ram_addr_d = base_q + DP_ADDR_WIDTH'(cnt_q + CNT_ONE);
        end
      end
      LD_LAST: begin
        ld_we   = 1'b1;
        ld_idx  = ADDR_WIDTH'(MATRIX_SIZE - 1);
        state_d = swap_q ? SWAP : FIN;
      end
      SWAP: begin
        ld_swap = 1'b1;
        state_d = FIN;
      end
      ST_SEL: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          shift_d = acc_out;
          byte_d  = '0;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        ram_we_d   = 1'b1;
        ram_addr_d = base_q + st_off;
        ram_din_d  = shift_q[DATA_WIDTH-1:0];
        shift_d    = shift_q >> DATA_WIDTH;
        if (byte_q == LAST_BYTE) begin
          byte_d = '0;
          if (cnt_q == ST_LASTK) begin
            state_d = FIN;
          end else begin
            cnt_d      = cnt_q + CNT_ONE;
            addr_acc_d = ACC_ADDR_WIDTH'(cnt_q + CNT_ONE);
            state_d    = ST_SEL;
          end
        end else begin
          byte_d = byte_q + BYTE_W'(1);
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    load_en_top_d  = ld_we & ~sel_left;
    load_en_left_d = ld_we & sel_left;
    swap_top_d     = ld_swap & ~sel_left;
    swap_left_d    = ld_swap & sel_left;
    addr_top_d     = load_en_top_d  ? ld_idx   : '0;
    addr_left_d    = load_en_left_d ? ld_idx   : '0;
    data_top_d     = load_en_top_d  ? ram_dout : '0;
    data_left_d    = load_en_left_d ? ram_dout : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      op_q           <= OP_LOAD_TOP;
      base_q         <= '0;
      swap_q         <= 1'b0;
      cnt_q          <= '0;
      byte_q         <= '0;
      phase_q        <= 1'b0;
      shift_q        <= '0;
      cmd_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_din_q      <= '0;
      load_en_top_q  <= 1'b0;
      swap_top_q     <= 1'b0;
      addr_top_q     <= '0;
      data_top_q     <= '0;
      load_en_left_q <= 1'b0;
      swap_left_q    <= 1'b0;
      addr_left_q    <= '0;
      data_left_q    <= '0;
      addr_acc_q     <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      base_q         <= base_d;
      swap_q         <= swap_d;
      cnt_q          <= cnt_d;
      byte_q         <= byte_d;
      phase_q        <= phase_d;
      shift_q        <= shift_d;
      cmd_ready_q    <= cmd_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_din_q      <= ram_din_d;
      load_en_top_q  <= load_en_top_d;
      swap_top_q     <= swap_top_d;
      addr_top_q     <= addr_top_d;
      data_top_q     <= data_top_d;
      load_en_left_q <= load_en_left_d;
      swap_left_q    <= swap_left_d;
      addr_left_q    <= addr_left_d;
      data_left_q    <= data_left_d;
      addr_acc_q     <= addr_acc_d;
    end
  end

  assign cmd.cmd_ready       = cmd_ready_q;
  assign cmd.busy            = busy_q;
  assign cmd.done            = done_q;
  assign cmd.err             = err_q;
  assign ram_we              = ram_we_q;
  assign ram_addr            = ram_addr_q;
  assign ram_din             = ram_din_q;
  assign load_en_top         = load_en_top_q;
  assign swap_buffers_top    = swap_top_q;
  assign addr_top            = addr_top_q;
  assign data_in_top         = data_top_q;
  assign load_en_left        = load_en_left_q;
  assign swap_buffers_left   = swap_left_q;
  assign addr_left           = addr_left_q;
  assign data_in_left        = data_left_q;
  assign addr_acc            = addr_acc_q;

endmodule

// File: tb/tb_systolic_dma_ctrl.sv
// Directed bench for systolic_dma_ctrl: RAM and accumulator models, an event monitor,
// and a linear sequence of commands checked with immediate assertions.
module tb_systolic_dma_ctrl;

  localparam int DW   = 8;
  localparam int DPW  = 10;
  localparam int AW   = 3;
  localparam int ACCW = 32;
  localparam int ACAW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_dma_ctrl_if #(.DP_ADDR_WIDTH(DPW)) cmd_if ();

  logic            ram_we;
  logic [DPW-1:0]  ram_addr;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout;
  logic            load_en_top, swap_buffers_top, load_en_left, swap_buffers_left;
  logic [AW-1:0]   addr_top, addr_left;
  logic [DW-1:0]   data_in_top, data_in_left;
  logic [ACAW-1:0] addr_acc;
  logic [ACCW-1:0] acc_out;

  systolic_dma_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .cmd               (cmd_if),
    .ram_we            (ram_we),
    .ram_addr          (ram_addr),
    .ram_din           (ram_din),
    .ram_dout          (ram_dout),
    .load_en_top       (load_en_top),
    .swap_buffers_top  (swap_buffers_top),
    .addr_top          (addr_top),
    .data_in_top       (data_in_top),
    .load_en_left      (load_en_left),
    .swap_buffers_left (swap_buffers_left),
    .addr_left         (addr_left),
    .data_in_left      (data_in_left),
    .addr_acc          (addr_acc),
    .acc_out           (acc_out)
  );

  // Synchronous-read RAM with a bench-side preload port, plus an accumulator bank model.
  logic [7:0]     mem [0:1023];
  logic           bk_we = 1'b0;
  logic [DPW-1:0] bk_addr = '0;
  logic [7:0]     bk_data = '0;

  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
    acc_out  <= 32'hA0B0C0D0 + 32'(addr_acc);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       top_n = 0, left_n = 0, swt_n = 0, swl_n = 0, done_n = 0, err_n = 0;
  int       we_n = 0, ovl_n = 0, acc_n = 0;
  int       swl_edge = 0, done_edge = 0, acc_edge = 0;
  logic [7:0] top_idx [64];
  logic [7:0] top_dat [64];
  int         top_edge[64];
  logic [7:0] left_idx[64];
  logic [7:0] left_dat[64];

  always @(negedge clk) begin
    if (load_en_top && top_n < 64) begin
      top_idx[top_n]  <= 8'(addr_top);
      top_dat[top_n]  <= data_in_top;
      top_edge[top_n] <= cyc;
      top_n <= top_n + 1;
    end
    if (load_en_left && left_n < 64) begin
      left_idx[left_n] <= 8'(addr_left);
      left_dat[left_n] <= data_in_left;
      left_n <= left_n + 1;
    end
    if (swap_buffers_top) swt_n <= swt_n + 1;
    if (swap_buffers_left) begin
      swl_n    <= swl_n + 1;
      swl_edge <= cyc;
    end
    if (cmd_if.done) begin
      done_n    <= done_n + 1;
      done_edge <= cyc;
    end
    if (cmd_if.err) err_n <= err_n + 1;
    if (ram_we) we_n <= we_n + 1;
    if (cmd_if.cmd_ready && cmd_if.busy) ovl_n <= ovl_n + 1;
    if (cmd_if.cmd_valid && cmd_if.cmd_ready && !rst) begin
      acc_n    <= acc_n + 1;
      acc_edge <= cyc + 1;
    end
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [DPW-1:0] a, input logic [7:0] d);
    bk_addr = a;
    bk_data = d;
    bk_we   = 1'b1;
    @(posedge clk);
    #1;
    bk_we   = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [DPW-1:0] base,
                                input logic swap, input string tag);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_base  = base;
    cmd_if.cmd_swap  = swap;
    cmd_if.cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cmd_if.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    check_output({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int snap, input int limit, input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      #1;
      if (done_n > snap) begin
        ok = 1'b1;
        break;
      end
    end
    check_output({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  int s_top, s_left, s_swt, s_swl, s_done, s_err, s_we, s_ovl, s_acc;
  int a1, a2, d1;
  bit got1, ok6;

  task automatic snapshot();
    s_top = top_n; s_left = left_n; s_swt = swt_n; s_swl = swl_n;
    s_done = done_n; s_err = err_n; s_we = we_n; s_ovl = ovl_n; s_acc = acc_n;
  endtask

  initial begin
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_base  = '0;
    cmd_if.cmd_swap  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check_output("rst_busy", 32'(cmd_if.busy), 32'd0);
    check_output("rst_done", 32'(cmd_if.done), 32'd0);
    check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 8; n++) poke(DPW'(10'h100 + n), 8'(8'h11 * (n + 1)));
    for (int n = 0; n < 8; n++) poke(DPW'(10'h3FC + n), 8'(8'hC0 + n));

    $display("[TB] LOAD_TOP base=0x100");
    snapshot();
    apply_stimulus(2'd0, 10'h100, 1'b0, "t1");
    wait_done(s_done, 50, "t1");
    check_output("t1_latency", 32'(done_edge - acc_edge), 32'd10);
    check_output("t1_top_writes", 32'(top_n - s_top), 32'd8);
    for (int n = 0; n < 8; n++) begin
      check_output($sformatf("t1_idx%0d", n), 32'(top_idx[s_top + n]), 32'(n));
      check_output($sformatf("t1_dat%0d", n), 32'(top_dat[s_top + n]), 32'(8'h11 * (n + 1)));
    end
    check_output("t1_consecutive", 32'(top_edge[s_top + 7] - top_edge[s_top]), 32'd7);
    check_output("t1_left_quiet", 32'(left_n - s_left), 32'd0);
    check_output("t1_no_ram_we", 32'(we_n - s_we), 32'd0);
    check_output("t1_no_swap", 32'(swt_n - s_swt), 32'd0);
    repeat (2) @(negedge clk);
    check_output("t1_ready_back", 32'(cmd_if.cmd_ready), 32'd1);

    $display("[TB] LOAD_LEFT base=0x3FC with swap");
    snapshot();
    apply_stimulus(2'd1, 10'h3FC, 1'b1, "t2");
    wait_done(s_done, 50, "t2");
    check_output("t2_latency", 32'(done_edge - acc_edge), 32'd11);
    check_output("t2_left_writes", 32'(left_n - s_left), 32'd8);
    for (int n = 0; n < 8; n++) begin
      check_output($sformatf("t2_idx%0d", n), 32'(left_idx[s_left + n]), 32'(n));
      check_output($sformatf("t2_dat%0d", n), 32'(left_dat[s_left + n]), 32'(8'hC0 + n));
    end
    check_output("t2_top_quiet", 32'(top_n - s_top), 32'd0);
    check_output("t2_swap_left", 32'(swl_n - s_swl), 32'd1);
    check_output("t2_swap_before_done", 32'(done_edge - swl_edge), 32'd1);
    check_output("t2_swap_top_quiet", 32'(swt_n - s_swt), 32'd0);

    $display("[TB] STORE_ACC base=0x200");
    snapshot();
    apply_stimulus(2'd2, 10'h200, 1'b0, "t3");
    wait_done(s_done, 500, "t3");
    check_output("t3_latency", 32'(done_edge - acc_edge), 32'd385);
    check_output("t3_we_count", 32'(we_n - s_we), 32'd256);
    check_output("t3_k0", {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]}, 32'hA0B0C0D0);
    check_output("t3_k1", {mem[10'h207], mem[10'h206], mem[10'h205], mem[10'h204]}, 32'hA0B0C0D1);
    check_output("t3_k63", {mem[10'h2FF], mem[10'h2FE], mem[10'h2FD], mem[10'h2FC]}, 32'hA0B0C10F);

    $display("[TB] illegal opcode");
    repeat (2) @(posedge clk);
    snapshot();
    apply_stimulus(2'd3, 10'h055, 1'b0, "t4");
    repeat (5) @(negedge clk);
    #1;
    check_output("t4_err_pulses", 32'(err_n - s_err), 32'd1);
    check_output("t4_no_done", 32'(done_n - s_done), 32'd0);
    check_output("t4_no_ram_we", 32'(we_n - s_we), 32'd0);
    check_output("t4_no_buf", 32'((top_n - s_top) + (left_n - s_left)), 32'd0);
    check_output("t4_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check_output("t4_busy", 32'(cmd_if.busy), 32'd0);

    $display("[TB] reset during STORE_ACC");
    snapshot();
    apply_stimulus(2'd2, 10'h300, 1'b0, "t5");
    ok6 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (addr_acc == ACAW'(5)) begin
        ok6 = 1'b1;
        break;
      end
    end
    check_output("t5_reached_k5", 32'(ok6), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_output("t5_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check_output("t5_busy", 32'(cmd_if.busy), 32'd0);
    check_output("t5_ram_we", 32'(ram_we), 32'd0);
    check_output("t5_ram_addr", 32'(ram_addr), 32'd0);
    check_output("t5_addr_acc", 32'(addr_acc), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_output("t5_no_partial_done", 32'(done_n - s_done), 32'd0);
    snapshot();
    apply_stimulus(2'd0, 10'h100, 1'b0, "t5b");
    wait_done(s_done, 50, "t5b");
    check_output("t5b_latency", 32'(done_edge - acc_edge), 32'd10);
    check_output("t5b_dat7", 32'(top_dat[s_top + 7]), 32'h88);

    $display("[TB] back-to-back loads with cmd_valid held");
    @(posedge clk);
    #1;
    snapshot();
    got1 = 1'b0;
    ok6  = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_base  = 10'h100;
    cmd_if.cmd_swap  = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      #1;
      if (!got1 && acc_n - s_acc >= 1) begin
        got1 = 1'b1;
        a1   = acc_edge;
      end
      if (acc_n - s_acc >= 2) begin
        ok6 = 1'b1;
        a2  = acc_edge;
        d1  = done_edge;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    check_output("t6_second_accept", 32'(ok6), 32'd1);
    wait_done(s_done + 1, 50, "t6");
    check_output("t6_first_latency", 32'(d1 - a1), 32'd10);
    check_output("t6_accept_after_done", 32'(a2 - d1), 32'd2);
    check_output("t6_second_latency", 32'(done_edge - a2), 32'd10);
    repeat (3) @(negedge clk);
    #1;
    check_output("t6_accept_count", 32'(acc_n - s_acc), 32'd2);
    check_output("t6_ready_busy_overlap", 32'(ovl_n - s_ovl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
